// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the data-memory bus adapter: FSM state codes,
// access-size encodings, byte-enable constants and the alignment rule.
package cpu_mem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] BE_ALL  = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  // Halves must sit on an even address, words on a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return (addr_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_repl.sv
// Replicates store data across all byte lanes so that whichever lanes
// the byte enables select already carry the correct bytes.
module store_lane_repl (
  input  logic [3:0]  mem_we,
  input  logic [31:0] mem_wdata,
  output logic [31:0] bus_wdata
);

  always_comb begin
    case (mem_we)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: bus_wdata = {4{mem_wdata[7:0]}};
      4'b0011, 4'b1100:                   bus_wdata = {2{mem_wdata[15:0]}};
      default:                            bus_wdata = mem_wdata;
    endcase
  end

endmodule

// File: rtl/dmem_bus_if.sv
// Data-memory bus adapter: single-outstanding request/grant/response with
// timeout abort. Define MISALIGN_CHECK_EN to reject misaligned half/word accesses.
module dmem_bus_if
  import cpu_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [3:0]  mem_we,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  state_t               state;
  logic [TIMEOUT_W-1:0] tcnt;
  logic [31:0]          repl_wdata;
  logic                 busy;
  logic                 timeout;
  logic                 bad_align;
  logic                 is_store;

  store_lane_repl u_store_lane_repl (
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .bus_wdata (repl_wdata)
  );

  assign busy     = (state == ST_REQ) || (state == ST_WAIT);
  assign is_store = (mem_we != BE_NONE);
  // Fires on the last allowed busy cycle, so it overrides a gnt/rvalid seen in that same cycle.
  assign timeout  = busy && (tcnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

`ifdef MISALIGN_CHECK_EN
  assign bad_align = is_misaligned(mem_size, mem_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign <= 1'b0;
    end else begin
      misalign <= (state == ST_IDLE) && mem_valid && bad_align;
    end
  end
`else
  logic unused_align_bits;
  assign unused_align_bits = ^{mem_size, mem_addr[1:0]};
  assign bad_align         = 1'b0;
  assign misalign          = 1'b0;
`endif

  always_comb begin
    case (state)
      ST_IDLE:         stall = mem_valid;
      ST_REQ, ST_WAIT: stall = 1'b1;
      default:         stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tcnt      <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= BE_NONE;
      bus_addr  <= '0;
      bus_wdata <= '0;
      done      <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          tcnt <= '0;
          if (mem_valid) begin
            if (bad_align) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state     <= ST_REQ;
              bus_req   <= 1'b1;
              bus_we    <= is_store;
              bus_be    <= is_store ? mem_we : BE_ALL;
              bus_addr  <= {mem_addr[31:2], 2'b00};
              bus_wdata <= repl_wdata;
            end
          end
        end
        ST_REQ: begin
          tcnt <= tcnt + TIMEOUT_W'(1);
          if (timeout) begin
            state   <= ST_DONE;
            bus_req <= 1'b0;
            rdata   <= '0;
            err     <= 1'b1;
            done    <= 1'b1;
          end else if (bus_gnt) begin
            bus_req <= 1'b0;
            state   <= bus_we ? ST_DONE : ST_WAIT;
            done    <= bus_we;
          end
        end
        ST_WAIT: begin
          tcnt <= tcnt + TIMEOUT_W'(1);
          if (timeout) begin
            state <= ST_DONE;
            rdata <= '0;
            err   <= 1'b1;
            done  <= 1'b1;
          end else if (bus_rvalid) begin
            state <= ST_DONE;
            rdata <= bus_rdata;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_if.sv
// Self-checking bench for dmem_bus_if: directed scenarios followed by random
// transactions, each predicted from the access outcome rules.
module tb_dmem_bus_if;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic [3:0]  mem_we = '0;
  logic [1:0]  mem_size = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        stall, done, err, misalign;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  int          ncomp = 0;
  int          nfail = 0;
  logic [31:0] model_rdata = '0;

  dmem_bus_if #(.TIMEOUT_CYCLES(T), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_we(mem_we),
    .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall(stall), .done(done), .rdata(rdata), .err(err), .misalign(misalign),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [3:0] we,
                               input logic [1:0] sz, input logic [31:0] a,
                               input logic [31:0] wd, input bit g, input bit rv,
                               input logic [31:0] rd);
    mem_valid  = v;
    mem_we     = we;
    mem_size   = sz;
    mem_addr   = a;
    mem_wdata  = wd;
    bus_gnt    = g;
    bus_rvalid = rv;
    bus_rdata  = rd;
  endtask

  function automatic logic [31:0] lanes(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  task automatic checkAllZero(input string name);
    checkOutput({name, ".done"},      32'(done),      32'd0);
    checkOutput({name, ".err"},       32'(err),       32'd0);
    checkOutput({name, ".misalign"},  32'(misalign),  32'd0);
    checkOutput({name, ".rdata"},     rdata,          32'd0);
    checkOutput({name, ".bus_req"},   32'(bus_req),   32'd0);
    checkOutput({name, ".bus_we"},    32'(bus_we),    32'd0);
    checkOutput({name, ".bus_be"},    32'(bus_be),    32'd0);
    checkOutput({name, ".bus_addr"},  bus_addr,       32'd0);
    checkOutput({name, ".bus_wdata"}, bus_wdata,      32'd0);
  endtask

  // g: REQ cycle (0-based) carrying gnt; r: WAIT cycle (0-based) carrying rvalid.
  task automatic runTxn(input string name, input bit is_store, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int g, input int r, input logic [31:0] rd,
                        input bit hold_after);
    logic [3:0] we;
    bit         mis, tmo, gv, rv;
    int         needed, busyc, reqc, gcyc, rcyc;
    if (!is_store)          we = 4'b0000;
    else if (sz == 2'b00)   we = 4'b0001 << addr[1:0];
    else if (sz == 2'b01)   we = addr[1] ? 4'b1100 : 4'b0011;
    else                    we = 4'b1111;
    mis = 1'b0;
`ifdef MISALIGN_CHECK_EN
    mis = (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
`endif
    needed = is_store ? g + 1 : g + 2 + r;
    if (mis) begin
      busyc = 0; reqc = 0; tmo = 1'b0;
    end else if (needed <= T - 1) begin
      busyc = needed; reqc = g + 1; tmo = 1'b0;
    end else begin
      busyc = T; reqc = (g + 1 < T) ? g + 1 : T; tmo = 1'b1;
    end
    gcyc = 1 + g;
    rcyc = 2 + g + r;
    for (int c = 0; c <= busyc + 1; c++) begin
      @(posedge clk); #1;
      gv = !mis && (c == gcyc) && (c <= busyc);
      if (mis)           rv = 1'b0;
      else if (is_store) rv = (c == busyc + 1);
      else               rv = (c == rcyc);
      applyStimulus(1'b1, we, sz, addr, wdata, gv, rv, is_store ? ~rd : rd);
      @(negedge clk);
      checkOutput({name, ".stall"},   32'(stall),   32'(c <= busyc));
      checkOutput({name, ".done"},    32'(done),    32'(c == busyc + 1));
      checkOutput({name, ".bus_req"}, 32'(bus_req), 32'(c >= 1 && c <= reqc));
      if (c >= 1 && c <= busyc) begin
        checkOutput({name, ".bus_addr"}, bus_addr,      addr & 32'hFFFF_FFFC);
        checkOutput({name, ".bus_be"},   32'(bus_be),   32'(is_store ? we : 4'b1111));
        checkOutput({name, ".bus_we"},   32'(bus_we),   32'(is_store));
        if (is_store)
          checkOutput({name, ".bus_wdata"}, bus_wdata, lanes(sz, wdata));
      end
      if (c == busyc + 1) begin
        if (tmo)                       model_rdata = 32'd0;
        else if (!is_store && !mis)    model_rdata = rd;
        checkOutput({name, ".rdata"},    rdata,          model_rdata);
        checkOutput({name, ".err"},      32'(err),       32'(tmo));
        checkOutput({name, ".misalign"}, 32'(misalign),  32'(mis));
      end
    end
    if (!hold_after) begin
      @(posedge clk); #1;
      applyStimulus(1'b0, 4'b0, 2'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      checkOutput({name, ".idle_stall"},   32'(stall),   32'd0);
      checkOutput({name, ".idle_done"},    32'(done),    32'd0);
      checkOutput({name, ".idle_bus_req"}, 32'(bus_req), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting dmem_bus_if bench, TIMEOUT_CYCLES=%0d", T);
    #2;
    checkAllZero("reset");
    checkOutput("reset.stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runTxn("sb",      1'b1, 2'b00, 32'h0000_1002, 32'h0000_00AB, 0, 0, 32'h0, 1'b0);
    runTxn("lw",      1'b0, 2'b10, 32'h0000_2000, 32'h0,         3, 1, 32'hDEAD_BEEF, 1'b0);
    runTxn("tmo",     1'b0, 2'b10, 32'h0000_2004, 32'h0,       999, 0, 32'h5555_5555, 1'b0);
    runTxn("tmo_gnt", 1'b1, 2'b10, 32'h0000_0040, 32'h1234_5678, T - 1, 0, 32'h0, 1'b0);
    runTxn("lw_edge", 1'b0, 2'b01, 32'h0000_0046, 32'h0,       0, T - 3, 32'h0000_A5A5, 1'b0);
    runTxn("lw_3001", 1'b0, 2'b10, 32'h0000_3001, 32'h0,       0, 0, 32'h0BAD_F00D, 1'b0);
    runTxn("b2b_sh",  1'b1, 2'b01, 32'h0000_2002, 32'h0000_BEEF, 0, 0, 32'h0, 1'b1);
    runTxn("b2b_lw",  1'b0, 2'b10, 32'h0000_2000, 32'h0,       0, 0, 32'hCAFE_F00D, 1'b0);

    // Reset while waiting for read data; the late response must be dropped.
    @(posedge clk); #1;
    applyStimulus(1'b1, 4'b0, 2'b10, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 4'b0, 2'b10, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 4'b0, 2'b10, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_wait.pre_stall",   32'(stall),   32'd1);
    checkOutput("rst_wait.pre_bus_req", 32'(bus_req), 32'd0);
    #2;
    rst_n = 1'b0;
    applyStimulus(1'b0, 4'b0, 2'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    checkAllZero("rst_wait");
    checkOutput("rst_wait.stall", 32'(stall), 32'd0);
    model_rdata = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      applyStimulus(1'b0, 4'b0, 2'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
      @(negedge clk);
      checkOutput("rst_wait.post_done",    32'(done),    32'd0);
      checkOutput("rst_wait.post_rdata",   rdata,        32'd0);
      checkOutput("rst_wait.post_bus_req", 32'(bus_req), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      bit         st;
      logic [1:0] sz;
      int         g;
      st = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2));
      g  = ($urandom_range(0, 5) == 0) ? 99 : int'($urandom_range(0, T));
      runTxn("rnd", st, sz, $urandom, $urandom, g, int'($urandom_range(0, 4)),
             $urandom, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
